// File: rtl/fm_tune_pkg.sv
// Shared types and constants for the FM tuning controller: FSM states,
// default band plan and the preset channel table.
package fm_tune_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STEP   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_REPEAT = 2'd3
    } tune_state_t;

    localparam int FREQ_MIN_DEF  = 87500000;
    localparam int FREQ_STEP_DEF = 100000;
    localparam int CH_MAX_DEF    = 205;

    localparam int PRESET_NUM = 4;
    localparam logic [7:0] PRESET_CH [PRESET_NUM] = '{8'd0, 8'd5, 8'd105, 8'd205};

endpackage

// File: rtl/fm_tune_ctrl_btn_debounce.sv
// Two-flop synchronizer followed by a stability counter for one raw button;
// the output level only follows after DEBOUNCE_CYC consecutive differing samples.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0    <= 1'b0;
            sync_p1    <= 1'b0;
            stable_cnt <= '0;
            level      <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            // Any sample matching the current level restarts the stability count.
            if (sync_p1 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= sync_p1;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/fm_tune_ctrl.sv
// Button-driven carrier tuner for fmgen with hold-to-repeat and a retune mute window.
// Define FM_TUNE_PRESET_EN to enable preset cycling on btn_center.
module fm_tune_ctrl
    import fm_tune_pkg::*;
#(
    parameter int FREQ_MIN         = FREQ_MIN_DEF,
    parameter int FREQ_STEP        = FREQ_STEP_DEF,
    parameter int CH_MAX           = CH_MAX_DEF,
    parameter int CH_INIT          = 205,
    parameter int DEBOUNCE_CYC     = 250000,
    parameter int REPEAT_DELAY_CYC = 12500000,
    parameter int REPEAT_RATE_CYC  = 2500000,
    parameter int MUTE_CYC         = 65536
) (
    input  logic        clk_25m,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_center,
    output logic [31:0] cw_freq,
    output logic [7:0]  channel,
    output logic        mute,
    output logic        freq_upd
);

    localparam logic [7:0]  CH_TOP = 8'(CH_MAX);
    localparam logic [7:0]  CH_RST = 8'(CH_INIT);
    localparam logic [31:0] F_MIN  = 32'(FREQ_MIN);
    localparam logic [31:0] F_STEP = 32'(FREQ_STEP);
    localparam logic [31:0] F_TOP  = 32'(FREQ_MIN + CH_MAX * FREQ_STEP);
    localparam logic [31:0] F_RST  = 32'(FREQ_MIN + CH_INIT * FREQ_STEP);
    localparam int TW = $clog2((REPEAT_DELAY_CYC > REPEAT_RATE_CYC ?
                                REPEAT_DELAY_CYC : REPEAT_RATE_CYC) + 1);
    localparam logic [TW-1:0] DELAY_LAST = TW'(REPEAT_DELAY_CYC - 1);
    localparam logic [TW-1:0] RATE_LAST  = TW'(REPEAT_RATE_CYC - 1);
    localparam int MW = $clog2(MUTE_CYC + 1);
    localparam logic [MW-1:0] MUTE_LOAD = MW'(MUTE_CYC);

    function automatic logic [7:0] step_channel(input logic [7:0] ch, input logic up);
        if (up) return (ch == CH_TOP) ? 8'd0 : ch + 8'd1;
        return (ch == 8'd0) ? CH_TOP : ch - 8'd1;
    endfunction

    function automatic logic [31:0] step_freq(input logic [7:0] ch, input logic [31:0] f,
                                              input logic up);
        if (up) return (ch == CH_TOP) ? F_MIN : f + F_STEP;
        return (ch == 8'd0) ? F_TOP : f - F_STEP;
    endfunction

    logic          deb_up, deb_down, up_d, down_d;
    logic          rise_up, rise_down, held_req, step_now, preset_go;
    tune_state_t   state;
    logic [TW-1:0] timer;
    logic          dir;
    logic          upd_p0, dir_p0;
    logic [MW-1:0] mute_cnt;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_up (
        .clk(clk_25m), .reset(reset), .btn(btn_up), .level(deb_up)
    );
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_down (
        .clk(clk_25m), .reset(reset), .btn(btn_down), .level(deb_down)
    );

    // A press only counts when its own button rises with the other one released.
    assign rise_up   = deb_up & ~up_d & ~deb_down;
    assign rise_down = deb_down & ~down_d & ~deb_up;
    assign held_req  = dir ? (deb_up & ~deb_down) : (deb_down & ~deb_up);
    assign step_now  = (state == ST_STEP) ||
                       (state == ST_REPEAT && held_req && timer == RATE_LAST);

`ifdef FM_TUNE_PRESET_EN
    localparam logic [31:0] PRESET_FREQ [PRESET_NUM] = '{
        32'(FREQ_MIN + int'(PRESET_CH[0]) * FREQ_STEP),
        32'(FREQ_MIN + int'(PRESET_CH[1]) * FREQ_STEP),
        32'(FREQ_MIN + int'(PRESET_CH[2]) * FREQ_STEP),
        32'(FREQ_MIN + int'(PRESET_CH[3]) * FREQ_STEP)
    };

    logic        deb_center, center_d, preset_p0;
    logic [1:0]  preset_idx;
    logic [7:0]  preset_ch_p0;
    logic [31:0] preset_freq_p0;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_center (
        .clk(clk_25m), .reset(reset), .btn(btn_center), .level(deb_center)
    );

    assign preset_go = deb_center & ~center_d & ~deb_up & ~deb_down & (state == ST_IDLE);

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            center_d   <= 1'b0;
            preset_idx <= 2'd0;
        end else begin
            center_d <= deb_center;
            if (preset_go) preset_idx <= preset_idx + 2'd1;
        end
    end
`else
    logic unused_center;
    assign unused_center = btn_center;
    assign preset_go     = 1'b0;
`endif

    always_ff @(posedge clk_25m) begin
        if (reset) begin
            state  <= ST_IDLE;
            timer  <= '0;
            dir    <= 1'b0;
            up_d   <= 1'b0;
            down_d <= 1'b0;
        end else begin
            up_d   <= deb_up;
            down_d <= deb_down;
            case (state)
                ST_IDLE: begin
                    if (rise_up || rise_down) begin
                        state <= ST_STEP;
                        dir   <= rise_up;
                    end
                end
                ST_STEP: begin
                    state <= ST_HOLD;
                    timer <= '0;
                end
                ST_HOLD: begin
                    if (!held_req) begin
                        state <= ST_IDLE;
                    end else if (timer == DELAY_LAST) begin
                        state <= ST_REPEAT;
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_REPEAT: begin
                    if (!held_req) state <= ST_IDLE;
                    else if (timer == RATE_LAST) timer <= '0;
                    else timer <= timer + TW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Stage p0: update request captured; mute rises here, one edge ahead of cw_freq.
    always_ff @(posedge clk_25m) begin
        dir_p0 <= dir;
`ifdef FM_TUNE_PRESET_EN
        preset_p0      <= preset_go;
        preset_ch_p0   <= PRESET_CH[preset_idx];
        preset_freq_p0 <= PRESET_FREQ[preset_idx];
`endif
    end

    // Stage p1: channel/cw_freq change together with the freq_upd strobe.
    always_ff @(posedge clk_25m) begin
        if (reset) begin
            upd_p0   <= 1'b0;
            freq_upd <= 1'b0;
            channel  <= CH_RST;
            cw_freq  <= F_RST;
            mute     <= 1'b0;
            mute_cnt <= '0;
        end else begin
            upd_p0   <= step_now | preset_go;
            freq_upd <= upd_p0;
            if (upd_p0) begin
`ifdef FM_TUNE_PRESET_EN
                if (preset_p0) begin
                    channel <= preset_ch_p0;
                    cw_freq <= preset_freq_p0;
                end else
`endif
                begin
                    channel <= step_channel(channel, dir_p0);
                    cw_freq <= step_freq(channel, cw_freq, dir_p0);
                end
            end
            if (upd_p0) mute_cnt <= MUTE_LOAD;
            else if (mute_cnt != '0) mute_cnt <= mute_cnt - MW'(1);
            if (step_now | preset_go) mute <= 1'b1;
            else if (mute_cnt == '0 && !upd_p0) mute <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fm_tune_ctrl.sv
// Directed and randomized bench for fm_tune_ctrl with a channel/mute reference model.
module tb_fm_tune_ctrl;

    localparam int DEB   = 4;
    localparam int DLY   = 20;
    localparam int RATE  = 8;
    localparam int MUTEC = 16;
    localparam int FMIN  = 87500000;
    localparam int FSTEP = 100000;
    localparam int CHMAX = 205;

    logic        clk_25m = 1'b0;
    logic        reset = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_center = 1'b0;
    logic [31:0] cw_freq;
    logic [7:0]  channel;
    logic        mute;
    logic        freq_upd;

    fm_tune_ctrl #(
        .DEBOUNCE_CYC(DEB), .REPEAT_DELAY_CYC(DLY),
        .REPEAT_RATE_CYC(RATE), .MUTE_CYC(MUTEC)
    ) dut (
        .clk_25m(clk_25m), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
        .btn_center(btn_center), .cw_freq(cw_freq), .channel(channel),
        .mute(mute), .freq_upd(freq_upd)
    );

    always #20 clk_25m = ~clk_25m;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int silent_chg = 0;
    int model_ch = CHMAX;
    logic [7:0]  last_ch = 8'd0;
    logic [31:0] last_f = 32'd0;
    int upd_cyc[$];
    int upd_ch[$];
    int upd_f[$];
    bit mute_q[$];
    int mcyc_q[$];

    always @(posedge clk_25m) cyc <= cyc + 1;

    // Monitor: logs every strobe and mute level, and flags changes without a strobe.
    always @(negedge clk_25m) begin
        mute_q.push_back(mute);
        mcyc_q.push_back(cyc);
        if (freq_upd) begin
            upd_cyc.push_back(cyc);
            upd_ch.push_back(int'(channel));
            upd_f.push_back(int'(cw_freq));
        end else if (!reset && (channel != last_ch || cw_freq != last_f)) begin
            silent_chg <= silent_chg + 1;
        end
        last_ch <= channel;
        last_f  <= cw_freq;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_25m);
            #1;
        end
    endtask

    // Expected step count for a clean press whose raw level is held for 'hold' cycles.
    function automatic int steps_for(input int hold);
        int n = 1;
        if (hold >= DLY + RATE + 2) n += (hold - (DLY + RATE + 2)) / RATE + 1;
        return n;
    endfunction

    task automatic expect_steps(input string tag, input int up, input int n_exp,
                                input int t0, input int idx0, input int sil0);
        int got, mism, base, gap;
        bit m_exp;
        int u_exp[$];
        got = upd_cyc.size() - idx0;
        chk({tag, "_count"}, got, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            model_ch = up ? (model_ch + 1) % (CHMAX + 1) : (model_ch + CHMAX) % (CHMAX + 1);
            if (i < got) begin
                chk({tag, "_ch"}, upd_ch[idx0 + i], model_ch);
                chk({tag, "_freq"}, upd_f[idx0 + i], FMIN + model_ch * FSTEP);
                if (i == 0) begin
                    chk({tag, "_latency_ok"},
                        (upd_cyc[idx0] - t0 >= DEB) && (upd_cyc[idx0] - t0 <= DEB + 10), 1);
                    u_exp.push_back(upd_cyc[idx0]);
                end else begin
                    gap = (i == 1) ? DLY + RATE : RATE;
                    chk({tag, "_interval"}, upd_cyc[idx0 + i] - upd_cyc[idx0 + i - 1], gap);
                    u_exp.push_back(u_exp[i - 1] + gap);
                end
            end
        end
        mism = 0;
        base = mcyc_q[0];
        for (int t = t0; t < cyc; t++) begin
            m_exp = 1'b0;
            foreach (u_exp[k]) if (t >= u_exp[k] - 1 && t <= u_exp[k] + MUTEC) m_exp = 1'b1;
            if (mute_q[t - base] != m_exp) mism++;
        end
        chk({tag, "_mute_window"}, mism, 0);
        chk({tag, "_silent_change"}, silent_chg - sil0, 0);
    endtask

    task automatic scen(input string tag, input logic up, input int hold, input int gap,
                        input int n_exp);
        int t0, idx0, sil0;
        t0 = cyc; idx0 = upd_cyc.size(); sil0 = silent_chg;
        btn_up = up; btn_down = ~up;
        tick(hold);
        btn_up = 1'b0; btn_down = 1'b0;
        tick(gap);
        expect_steps(tag, up, n_exp, t0, idx0, sil0);
    endtask

    initial begin
        int t0, idx0, sil0, hold;
        logic up;
`ifdef FM_TUNE_PRESET_EN
        int pch[3] = '{0, 5, 105};
        int pf[3]  = '{87500000, 88000000, 98000000};
`endif
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("reset_channel", channel, 205);
        chk("reset_freq", cw_freq, 108000000);
        chk("reset_mute", mute, 0);
        chk("reset_upd", freq_upd, 0);

        // Reset while auto-repeating aborts back to the initial channel.
        btn_up = 1'b1;
        tick(40);
        chk("prereset_mute", mute, 1);
        chk("prereset_moved", channel != 8'd205, 1);
        reset = 1'b1; btn_up = 1'b0;
        tick(1);
        chk("midrep_reset_channel", channel, 205);
        chk("midrep_reset_freq", cw_freq, 108000000);
        chk("midrep_reset_mute", mute, 0);
        chk("midrep_reset_upd", freq_upd, 0);
        reset = 1'b0;
        idx0 = upd_cyc.size();
        tick(30);
        chk("post_reset_quiet", upd_cyc.size() - idx0, 0);
        model_ch = CHMAX;

        scen("up_wrap", 1'b1, 10, 30, 1);
        scen("down_repeat", 1'b0, 60, 30, steps_for(60));

        // Bouncing button never settles long enough to register.
        t0 = cyc; idx0 = upd_cyc.size(); sil0 = silent_chg;
        for (int i = 0; i < 15; i++) begin
            btn_up = ~btn_up;
            tick(2);
        end
        btn_up = 1'b0;
        tick(20);
        expect_steps("bounce", 1, 0, t0, idx0, sil0);

        // Both held, then down released: up must be released and pressed again.
        t0 = cyc; idx0 = upd_cyc.size(); sil0 = silent_chg;
        btn_up = 1'b1; btn_down = 1'b1;
        tick(20);
        btn_down = 1'b0;
        tick(30);
        btn_up = 1'b0;
        tick(30);
        expect_steps("both_held", 1, 0, t0, idx0, sil0);
        scen("repress_up", 1'b1, 10, 30, 1);

        for (int r = 0; r < 10; r++) begin
            up = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) hold = $urandom_range(6, 22);
            else hold = DLY + RATE + 2 + RATE * $urandom_range(0, 3) + $urandom_range(2, 5);
            scen("random", up, hold, 30, steps_for(hold));
        end

`ifdef FM_TUNE_PRESET_EN
        for (int p = 0; p < 3; p++) begin
            idx0 = upd_cyc.size();
            btn_center = 1'b1;
            tick(8);
            btn_center = 1'b0;
            tick(30);
            chk("preset_count", upd_cyc.size() - idx0, 1);
            if (upd_cyc.size() > idx0) begin
                chk("preset_ch", upd_ch[idx0], pch[p]);
                chk("preset_freq", upd_f[idx0], pf[p]);
            end
            model_ch = pch[p];
        end
        t0 = cyc; idx0 = upd_cyc.size(); sil0 = silent_chg;
        btn_up = 1'b1;
        tick(8);
        btn_center = 1'b1;
        tick(6);
        btn_center = 1'b0;
        tick(2);
        btn_up = 1'b0;
        tick(30);
        expect_steps("preset_ignored", 1, 1, t0, idx0, sil0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
